// File: rtl/mac_stop_pkg.sv
// Shared types and sizing helpers for the matrix MAC operand store.
package mac_stop_pkg;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, SERVE} store_state_t;

    localparam int unsigned DEF_M = 2;
    localparam int unsigned DEF_K = 2;
    localparam int unsigned DEF_N = 2;
    localparam int unsigned A_ELEMS = DEF_M * DEF_K;
    localparam int unsigned B_ELEMS = DEF_K * DEF_N;

    // Load index must span the larger of the two matrices; never narrower than 1 bit.
    function automatic int unsigned idx_width(input int unsigned a_elems,
                                              input int unsigned b_elems);
        int unsigned mx;
        mx = (a_elems > b_elems) ? a_elems : b_elems;
        return (mx > 1) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/mac_stop_matrix_bank.sv
// One matrix storage bank: single write port, registered read port that returns 0 on error.
module mac_stop_matrix_bank #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic             rd_err,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (rd_err) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mac_stop_matrix_store.sv
// Operand store for the MAC engine: streams in A then B, then serves addressed reads.
module mac_stop_matrix_store
    import mac_stop_pkg::*;
#(
    parameter int unsigned M = 2,
    parameter int unsigned K = 2,
    parameter int unsigned N = 2,
    parameter int unsigned DATA_WIDTH_INIT_MATRIX = 32,
    localparam int unsigned RW_A = (M > 1) ? $clog2(M) : 1,
    localparam int unsigned CW_A = (K > 1) ? $clog2(K) : 1,
    localparam int unsigned RW_B = (K > 1) ? $clog2(K) : 1,
    localparam int unsigned CW_B = (N > 1) ? $clog2(N) : 1
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              load_valid,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0] load_data,
    output logic                              load_ready,
    input  logic                              reload,
    output logic                              store_ready,
    input  logic                              matrix_a_re,
    input  logic                              matrix_b_re,
    input  logic [RW_A-1:0]                   row_addr_a,
    input  logic [CW_A-1:0]                   col_addr_a,
    input  logic [RW_B-1:0]                   row_addr_b,
    input  logic [CW_B-1:0]                   col_addr_b,
    output logic [DATA_WIDTH_INIT_MATRIX-1:0] data_out_a,
    output logic [DATA_WIDTH_INIT_MATRIX-1:0] data_out_b,
    output logic                              read_err
);

    localparam int unsigned NUM_A = M * K;
    localparam int unsigned NUM_B = K * N;
    localparam int unsigned IW    = idx_width(NUM_A, NUM_B);
    localparam int unsigned AW_A  = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int unsigned AW_B  = (NUM_B > 1) ? $clog2(NUM_B) : 1;

    store_state_t    state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            hs, we_a, we_b;
    logic            err_a, err_b, read_err_q;
    logic [AW_A-1:0] addr_a;
    logic [AW_B-1:0] addr_b;

    assign load_ready  = (state_q != SERVE) && !reload;
    assign store_ready = (state_q == SERVE);
    assign hs          = load_valid && load_ready;

    assign addr_a = AW_A'(32'(row_addr_a) * K + 32'(col_addr_a));
    assign addr_b = AW_B'(32'(row_addr_b) * N + 32'(col_addr_b));

    // Out-of-range coordinates only occur for non-power-of-two dimensions.
    assign err_a = matrix_a_re &&
                   ((state_q != SERVE) || (32'(row_addr_a) >= M) || (32'(col_addr_a) >= K));
    assign err_b = matrix_b_re &&
                   ((state_q != SERVE) || (32'(row_addr_b) >= K) || (32'(col_addr_b) >= N));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= LOAD_A;
            idx_q      <= '0;
            read_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            read_err_q <= err_a || err_b;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_a    = 1'b0;
        we_b    = 1'b0;
        // reload wins over a coincident handshake (load_ready is already low).
        if (reload) begin
            state_d = LOAD_A;
            idx_d   = '0;
        end else if (hs) begin
            unique case (state_q)
                LOAD_A: begin
                    we_a = 1'b1;
                    if (idx_q == IW'(NUM_A - 1)) begin
                        idx_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                LOAD_B: begin
                    we_b = 1'b1;
                    if (idx_q == IW'(NUM_B - 1)) begin
                        idx_d   = '0;
                        state_d = SERVE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign read_err = read_err_q;

    mac_stop_matrix_bank #(
        .DEPTH (NUM_A),
        .WIDTH (DATA_WIDTH_INIT_MATRIX)
    ) u_bank_a (
        .clk    (clk),
        .resetn (resetn),
        .we     (we_a),
        .waddr  (AW_A'(idx_q)),
        .wdata  (load_data),
        .re     (matrix_a_re),
        .rd_err (err_a),
        .raddr  (addr_a),
        .rdata  (data_out_a)
    );

    mac_stop_matrix_bank #(
        .DEPTH (NUM_B),
        .WIDTH (DATA_WIDTH_INIT_MATRIX)
    ) u_bank_b (
        .clk    (clk),
        .resetn (resetn),
        .we     (we_b),
        .waddr  (AW_B'(idx_q)),
        .wdata  (load_data),
        .re     (matrix_b_re),
        .rd_err (err_b),
        .raddr  (addr_b),
        .rdata  (data_out_b)
    );

endmodule

// File: tb/tb_mac_stop_matrix_store.sv
// Scoreboard bench: stimulus pushes expected outputs, a monitor pops and compares them.
module tb_mac_stop_matrix_store;

    typedef struct packed {
        logic        dut;
        logic [31:0] a;
        logic [31:0] b;
        logic        err;
        logic        lr;
        logic        sr;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // DUT0: M=K=N=2
    logic        lv0 = 0, rl0 = 0, rea0 = 0, reb0 = 0;
    logic [31:0] ld0 = 0;
    logic [0:0]  ra0 = 0, ca0 = 0, rb0 = 0, cb0 = 0;
    logic        lr0, sr0, er0;
    logic [31:0] da0, db0;

    // DUT1: M=3, K=N=2
    logic        lv1 = 0, rl1 = 0, rea1 = 0, reb1 = 0;
    logic [31:0] ld1 = 0;
    logic [1:0]  ra1 = 0;
    logic [0:0]  ca1 = 0, rb1 = 0, cb1 = 0;
    logic        lr1, sr1, er1;
    logic [31:0] da1, db1;

    mac_stop_matrix_store #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(32)) dut0 (
        .clk(clk), .resetn(resetn), .load_valid(lv0), .load_data(ld0), .load_ready(lr0),
        .reload(rl0), .store_ready(sr0), .matrix_a_re(rea0), .matrix_b_re(reb0),
        .row_addr_a(ra0), .col_addr_a(ca0), .row_addr_b(rb0), .col_addr_b(cb0),
        .data_out_a(da0), .data_out_b(db0), .read_err(er0)
    );

    mac_stop_matrix_store #(.M(3), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(32)) dut1 (
        .clk(clk), .resetn(resetn), .load_valid(lv1), .load_data(ld1), .load_ready(lr1),
        .reload(rl1), .store_ready(sr1), .matrix_a_re(rea1), .matrix_b_re(reb1),
        .row_addr_a(ra1), .col_addr_a(ca1), .row_addr_b(rb1), .col_addr_b(cb1),
        .data_out_a(da1), .data_out_b(db1), .read_err(er1)
    );

    exp_t exp_q[$];
    logic chk_req = 1'b0;
    logic pend = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   step = 0;

    function automatic exp_t ex0(input logic [31:0] a, input logic [31:0] b, input logic err,
                                 input logic lr, input logic sr);
        ex0 = '{dut: 1'b0, a: a, b: b, err: err, lr: lr, sr: sr};
    endfunction

    function automatic exp_t ex1(input logic [31:0] a, input logic [31:0] b, input logic err,
                                 input logic lr, input logic sr);
        ex1 = '{dut: 1'b1, a: a, b: b, err: err, lr: lr, sr: sr};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (check %0d): got %0d, expected %0d", nm, step, act, exp);
        end
    endtask

    // Monitor: outputs after edge t are compared at the following negedge.
    always @(posedge clk) pend <= chk_req;

    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            step++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow (check %0d): got empty queue, expected entry",
                         step);
            end else begin
                e = exp_q.pop_front();
                if (e.dut) begin
                    check("dut1_data_out_a", da1, e.a);
                    check("dut1_data_out_b", db1, e.b);
                    check("dut1_read_err", 32'(er1), 32'(e.err));
                    check("dut1_load_ready", 32'(lr1), 32'(e.lr));
                    check("dut1_store_ready", 32'(sr1), 32'(e.sr));
                end else begin
                    check("data_out_a", da0, e.a);
                    check("data_out_b", db0, e.b);
                    check("read_err", 32'(er0), 32'(e.err));
                    check("load_ready", 32'(lr0), 32'(e.lr));
                    check("store_ready", 32'(sr0), 32'(e.sr));
                end
            end
        end
    end

    task automatic idle_all();
        lv0 = 0; ld0 = 0; rl0 = 0; rea0 = 0; reb0 = 0; ra0 = 0; ca0 = 0; rb0 = 0; cb0 = 0;
        lv1 = 0; ld1 = 0; rl1 = 0; rea1 = 0; reb1 = 0; ra1 = 0; ca1 = 0; rb1 = 0; cb1 = 0;
    endtask

    task automatic cyc(input bit t, input bit v, input int d, input bit rl,
                       input bit rea, input int ra, input int ca,
                       input bit reb, input int rb, input int cb, input exp_t e);
        @(negedge clk);
        #1;
        idle_all();
        if (!t) begin
            lv0 = v; ld0 = d; rl0 = rl; rea0 = rea; ra0 = ra[0]; ca0 = ca[0];
            reb0 = reb; rb0 = rb[0]; cb0 = cb[0];
        end else begin
            lv1 = v; ld1 = d; rl1 = rl; rea1 = rea; ra1 = ra[1:0]; ca1 = ca[0];
            reb1 = reb; rb1 = rb[0]; cb1 = cb[0];
        end
        exp_q.push_back(e);
        chk_req = 1'b1;
    endtask

    task automatic ld(input bit t, input bit v, input int d, input bit rl, input exp_t e);
        cyc(t, v, d, rl, 0, 0, 0, 0, 0, 0, e);
    endtask

    task automatic rd(input bit t, input bit rea, input int ra, input int ca,
                      input bit reb, input int rb, input int cb, input exp_t e);
        cyc(t, 0, 0, 0, rea, ra, ca, reb, rb, cb, e);
    endtask

    task automatic rcyc(input bit lvl, input exp_t e);
        @(negedge clk);
        #1;
        idle_all();
        resetn = lvl;
        exp_q.push_back(e);
        chk_req = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        rcyc(0, ex0(0, 0, 0, 1, 0));
        rcyc(0, ex0(0, 0, 0, 1, 0));
        rcyc(1, ex0(0, 0, 0, 1, 0));

        // A = 1..4, B = 5..8, valid held high
        for (int i = 1; i <= 8; i++) ld(0, 1, i, 0, ex0(0, 0, 0, i < 8, i == 8));
        rd(0, 1, 1, 0, 1, 0, 1, ex0(3, 6, 0, 0, 1));
        rd(0, 0, 0, 0, 0, 0, 0, ex0(3, 6, 0, 0, 1));
        rd(0, 0, 0, 0, 0, 0, 0, ex0(3, 6, 0, 0, 1));
        rd(0, 1, 0, 0, 1, 1, 1, ex0(1, 8, 0, 0, 1));
        rd(0, 1, 0, 1, 1, 1, 0, ex0(2, 7, 0, 0, 1));
        ld(0, 1, 77, 0, ex0(2, 7, 0, 0, 1));

        // Reload from SERVE, then toggled-valid load of 9..16 with illegal reads mixed in
        ld(0, 0, 0, 1, ex0(2, 7, 0, 0, 0));
        for (int i = 9; i <= 12; i++) begin
            ld(0, 1, i, 0, ex0(2, 7, 0, 1, 0));
            if (i < 12) ld(0, 0, 99, 0, ex0(2, 7, 0, 1, 0));
        end
        cyc(0, 0, 99, 0, 1, 0, 0, 0, 0, 0, ex0(0, 7, 1, 1, 0));
        for (int i = 13; i <= 15; i++) begin
            ld(0, 1, i, 0, ex0(0, 7, 0, 1, 0));
            ld(0, 0, 99, 0, ex0(0, 7, 0, 1, 0));
        end
        cyc(0, 1, 16, 0, 0, 0, 0, 1, 0, 0, ex0(0, 0, 1, 0, 1));
        ld(0, 0, 99, 0, ex0(0, 0, 0, 0, 1));
        rd(0, 1, 0, 0, 1, 1, 1, ex0(9, 16, 0, 0, 1));
        rd(0, 1, 1, 1, 1, 0, 0, ex0(12, 13, 0, 0, 1));
        rd(0, 1, 0, 1, 1, 1, 0, ex0(10, 15, 0, 0, 1));

        // Reload coincident with the handshake at idx 2 drops that element
        ld(0, 0, 0, 1, ex0(10, 15, 0, 0, 0));
        ld(0, 1, 21, 0, ex0(10, 15, 0, 1, 0));
        ld(0, 1, 22, 0, ex0(10, 15, 0, 1, 0));
        ld(0, 1, 23, 1, ex0(10, 15, 0, 0, 0));
        for (int i = 31; i <= 38; i++) ld(0, 1, i, 0, ex0(10, 15, 0, i < 38, i == 38));
        rd(0, 1, 0, 0, 1, 0, 1, ex0(31, 36, 0, 0, 1));
        rd(0, 1, 1, 0, 1, 1, 1, ex0(33, 38, 0, 0, 1));
        rd(0, 1, 0, 1, 0, 0, 0, ex0(32, 38, 0, 0, 1));

        // Reset in the middle of LOAD_B
        ld(0, 0, 0, 1, ex0(32, 38, 0, 0, 0));
        for (int i = 51; i <= 56; i++) ld(0, 1, i, 0, ex0(32, 38, 0, 1, 0));
        rcyc(0, ex0(0, 0, 0, 1, 0));
        rcyc(0, ex0(0, 0, 0, 1, 0));
        rcyc(1, ex0(0, 0, 0, 1, 0));
        for (int i = 41; i <= 48; i++) ld(0, 1, i, 0, ex0(0, 0, 0, i < 48, i == 48));
        rd(0, 1, 0, 0, 1, 0, 0, ex0(41, 45, 0, 0, 1));
        rd(0, 1, 1, 1, 1, 1, 1, ex0(44, 48, 0, 0, 1));

        // M=3 instance: out-of-range row 3 in SERVE
        for (int i = 61; i <= 70; i++) ld(1, 1, i, 0, ex1(0, 0, 0, i < 70, i == 70));
        rd(1, 1, 2, 1, 1, 1, 0, ex1(66, 69, 0, 0, 1));
        rd(1, 1, 3, 0, 0, 0, 0, ex1(0, 69, 1, 0, 1));
        rd(1, 1, 1, 0, 1, 0, 1, ex1(63, 68, 0, 0, 1));
        rd(1, 0, 0, 0, 0, 0, 0, ex1(63, 68, 0, 0, 1));

        // Drain the scoreboard
        @(negedge clk);
        #1;
        idle_all();
        chk_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_stop_matrix_store.md
# mac_stop_matrix_store

Operand storage and read responder for the matrix MAC datapath. Accepts matrix A (M×K) and matrix B (K×N) as one row-major element stream over a valid/ready load port. It then serves the MAC engine's row/column-addressed reads with registered, one-cycle-latency data. It is the memory-side counterpart of the MAC read interface: it consumes `row_addr_*`, `col_addr_*` and `matrix_*_re`, and returns the values that feed `data_in_a` and `data_in_b`.

## Interface
- `M`, 2, rows of A
- `K`, 2, columns of A / rows of B
- `N`, 2, columns of B
- `DATA_WIDTH_INIT_MATRIX`, 32, element width
- `clk` in 1, single clock, rising edge
- `resetn` in 1, asynchronous active-low reset
- `load_valid` in 1, load element valid
- `load_data` in DATA_WIDTH_INIT_MATRIX, load element, row-major, all of A then all of B
- `load_ready` out 1, block accepts load element
- `reload` in 1, synchronous request to restart loading
- `store_ready` out 1, both matrices loaded; reads are legal
- `matrix_a_re`, `matrix_b_re` in 1, read enables
- `row_addr_a` in $clog2(M), `col_addr_a` in $clog2(K), `row_addr_b` in $clog2(K), `col_addr_b` in $clog2(N), read addresses
- `data_out_a`, `data_out_b` out DATA_WIDTH_INIT_MATRIX, registered read data
- `read_err` out 1, one-cycle pulse for an illegal read

## Operation
- FSM states: LOAD_A, LOAD_B, SERVE. Reset state is LOAD_A.
- `load_ready` = (state is LOAD_A or LOAD_B) && !`reload`. A handshake is `load_valid && load_ready`.
- LOAD_A: each handshake writes `mem_a[idx]` and increments `idx`. The handshake at `idx == M*K-1` clears `idx` and moves to LOAD_B.
- LOAD_B: the same behaviour into `mem_b`. The handshake at `idx == K*N-1` clears `idx` and moves to SERVE.
- SERVE: `store_ready = 1` and `load_ready = 0`. `load_valid` is ignored.
- Read address mapping: A is `row*K + col`; B is `row*N + col`.
- `matrix_a_re` in SERVE with an in-range address: `data_out_a <= mem_a[...]`. B behaves the same way.
- Illegal read is either of:
  - any `re` while not in SERVE;
  - a row or column at or beyond M/K/N. This is possible when the dimension is not a power of two.
- On an illegal read: that port's data register loads 0 and `read_err` pulses. A and B errors are ORed.
- With no `re`, the data register holds its value.
- `reload`, in any state: next state is LOAD_A, `idx` clears, `store_ready` drops.
  - Memory contents are retained until overwritten.
  - `reload` has priority over a coincident handshake; that element is not accepted.
- Reset mid-load: state LOAD_A, `idx = 0`. Memory contents are undefined and need not be reset.

## Timing
- Reset values: `load_ready = 1`, `store_ready = 0`, `data_out_a = data_out_b = 0`, `read_err = 0`.
- Read latency is exactly 1 cycle: `re` and address sampled at edge t, data valid after edge t. A back-to-back `re` every cycle gives one result per cycle.
- `store_ready` rises the cycle after the final B handshake. A read issued in that same final-handshake cycle is illegal.
- Load throughput is one element per cycle. Total load is M*K + K*N handshakes.
- `read_err` is high for exactly the cycle after the offending request.

## Structure
- Package `mac_stop_pkg` holds:
  - the state enum `store_state_t` {LOAD_A, LOAD_B, SERVE};
  - the element counts `A_ELEMS = M*K`, `B_ELEMS = K*N`;
  - a width function for the load index, `$clog2(max(A_ELEMS, B_ELEMS))`.
- Sub-module `mac_stop_matrix_bank`, instantiated twice (A and B):
  - parameterized depth and width;
  - one write port and one registered read port with zero-on-error.
- The top level holds the FSM, index counter, address flattening and range checks.

## Test plan
- Reset, then load A = 1,2,3,4 and B = 5,6,7,8 with `load_valid` held high (M=K=N=2) -> `load_ready` high for 8 cycles; `store_ready` rises on the 9th cycle; `load_ready` drops.
- Load with `load_valid` toggling 1,0,1,0 -> exactly 8 accepted elements; contents match the stream order.
- In SERVE, `re` both ports for 1 cycle with A(1,0) and B(0,1) -> next cycle `data_out_a = 3`, `data_out_b = 6`; data holds for the following idle cycles.
- Issue `matrix_a_re` during LOAD_B -> `data_out_a = 0` and `read_err = 1` for one cycle. With M=3, read row 3 in SERVE -> same response.
- Assert `reload` in SERVE, then load A = 9..12 and B = 13..16 -> A(0,0) reads 9 and B(1,1) reads 16. Assert `reload` coincident with a handshake at `idx == 2` -> that element is dropped and the restart begins at A[0].
- Assert `resetn` low mid-LOAD_B -> outputs return to their reset values; the next 8 handshakes land in A then B from index 0.
